// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//
// Debounces two coin sensors, queues accepted coins, and replays them to the
// vending machine as well-separated one-cycle pulses while keeping a credit
// total.
//
// Each sensor passes through a two-flop synchronizer and then a debouncer.
// The debouncer holds a stable level and a counter of consecutive cycles in
// which the synchronized input disagreed with it. A rising stable level is a
// coin event. Events are either rejected (accept_en low, or queue full) or
// pushed into a 4-entry FIFO (0 = $10, 1 = $50). An output FSM pops one entry
// at a time and emits dollar_10 / dollar_50, then idles for two cycles.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   coin_10_raw  raw $10 sensor level (asynchronous, bouncy)
//   coin_50_raw  raw $50 sensor level (asynchronous, bouncy)
//   accept_en    1 = accept detected coins, 0 = reject every detected coin
//   credit_clr   synchronous clear of credit (wins over a same-edge pop)
//   dollar_10    one-cycle pulse per delivered $10 coin
//   dollar_50    one-cycle pulse per delivered $50 coin
//   coin_reject  one-cycle pulse per edge on which 1 or 2 coins were rejected
//   q_level      queue occupancy, 0..4
//   credit       delivered value in $10 units, saturating at 255
//   fsm_state    debug view of the output FSM (0 = IDLE, 1 = PULSE, 2 = GAP)
// -----------------------------------------------------------------------------
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_10_raw,
    input  logic       coin_50_raw,
    input  logic       accept_en,
    input  logic       credit_clr,
    output logic       dollar_10,
    output logic       dollar_50,
    output logic       coin_reject,
    output logic [2:0] q_level,
    output logic [7:0] credit,
    output logic [1:0] fsm_state
);

    // Queue depth is fixed: pointer and level widths below are sized for 4.
    localparam int QDEPTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // The level flips on the edge where the disagreement count would reach
    // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 = $10 sensor, 1 = $50 sensor.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stb;
    logic [1:0]      flip;
    logic [1:0]      coin_event;
    logic [1:0][7:0] cnt;

    logic [QDEPTH-1:0] mem;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        level;
    logic [2:0]        free;
    logic [1:0]        accepted;
    logic              push_10;
    logic              push_50;
    logic [1:0]        n_push;
    logic              pop;
    logic              head;
    logic              reject_now;
    logic [8:0]        credit_sum;
    logic [1:0]        state;

    assign raw = {coin_50_raw, coin_10_raw};

    // ------------------------------------------------------------------
    // Synchronizers and debouncers
    // ------------------------------------------------------------------
    always_comb begin
        flip = 2'b00;
        for (int i = 0; i < 2; i++) begin
            flip[i] = (sync2[i] != stb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Only a 0->1 change of the stable level counts as a coin.
    assign coin_event = flip & sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            stb   <= 2'b00;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            stb   <= stb ^ flip;
            for (int i = 0; i < 2; i++) begin
                if ((sync2[i] == stb[i]) || flip[i]) begin
                    cnt[i] <= 8'd0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Coin queue
    // ------------------------------------------------------------------
    // Free space is judged on the occupancy before this edge; a pop on the
    // same edge does not make room for a coin arriving on that edge.
    assign free     = 3'(QDEPTH) - level;
    assign accepted = coin_event & {2{accept_en}};
    // $10 is taken first, so $50 needs a second free slot when both arrive.
    assign push_10  = accepted[0] && (free != 3'd0);
    assign push_50  = accepted[1] && (free > {2'b00, push_10});
    assign n_push   = {1'b0, push_10} + {1'b0, push_50};

    assign reject_now = ((coin_event != 2'b00) && !accept_en)
                      || (accepted[0] && !push_10)
                      || (accepted[1] && !push_50);

    assign head = mem[rd_ptr];
    assign pop  = (state == S_IDLE) && (level != 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else begin
            if (push_10) begin
                mem[wr_ptr] <= 1'b0;
            end
            if (push_50) begin
                mem[wr_ptr + {1'b0, push_10}] <= 1'b1;
            end
            wr_ptr <= wr_ptr + n_push;
            rd_ptr <= rd_ptr + {1'b0, pop};
            level  <= level + {1'b0, n_push} - {2'b00, pop};
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: IDLE -> PULSE -> GAP -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            dollar_10 <= 1'b0;
            dollar_50 <= 1'b0;
        end else begin
            dollar_10 <= 1'b0;
            dollar_50 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        dollar_10 <= !head;
                        dollar_50 <= head;
                        state     <= S_PULSE;
                    end
                end
                S_PULSE: state <= S_GAP;
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reject pulse and credit
    // ------------------------------------------------------------------
    assign credit_sum = {1'b0, credit} + (head ? 9'd5 : 9'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_reject <= 1'b0;
            credit      <= 8'd0;
        end else begin
            coin_reject <= reject_now;
            if (credit_clr) begin
                credit <= 8'd0;
            end else if (pop) begin
                credit <= credit_sum[8] ? 8'hFF : credit_sum[7:0];
            end
        end
    end

    assign q_level   = level;
    assign fsm_state = state;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//
// Two instances share all inputs: dut_a with DEBOUNCE_CYCLES=4 and dut_b with
// DEBOUNCE_CYCLES=2 (the short debounce lets coins arrive faster than the
// output FSM drains them, so the queue can fill). A reference model per unit
// predicts every output on every cycle:
//   - debounce: the stable level flips when the raw samples taken 2..D+1
//     edges ago all disagree with it; a 0->1 flip is a coin;
//   - queue: a plain array of coin kinds, shifted on pop;
//   - output: after each delivery the next pop is allowed 3 edges later.
// Directed scenarios add hand-derived expectations on top.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       coin_10_raw;
  logic       coin_50_raw;
  logic       accept_en;
  logic       credit_clr;

  logic       d10_a, d50_a, rej_a, d10_b, d50_b, rej_b;
  logic [2:0] lvl_a, lvl_b;
  logic [7:0] cr_a, cr_b;
  logic [1:0] st_a, st_b;

  coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .coin_10_raw(coin_10_raw), .coin_50_raw(coin_50_raw),
    .accept_en(accept_en), .credit_clr(credit_clr), .dollar_10(d10_a), .dollar_50(d50_a),
    .coin_reject(rej_a), .q_level(lvl_a), .credit(cr_a), .fsm_state(st_a)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .coin_10_raw(coin_10_raw), .coin_50_raw(coin_50_raw),
    .accept_en(accept_en), .credit_clr(credit_clr), .dollar_10(d10_b), .dollar_50(d50_b),
    .coin_reject(rej_b), .q_level(lvl_b), .credit(cr_b), .fsm_state(st_b)
  );

  // ---------------- counters ----------------
  int n_asserts = 0;
  int n_fail    = 0;

  // ---------------- reference model ----------------
  int dval [2] = '{4, 2};
  bit h10 [2][16];
  bit h50 [2][16];
  bit m_stb10 [2];
  bit m_stb50 [2];
  bit mq [2][4];
  int mq_n [2];
  int busy [2];
  int m_cr [2];
  bit e_d10 [2];
  bit e_d50 [2];
  bit e_rej [2];

  // ---------------- scenario statistics ----------------
  int scen_t;
  int cnt10 [2];
  int cnt50 [2];
  int cntrej [2];
  int first10 [2];
  int first50 [2];
  int maxlvl [2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int u);
    for (int i = 0; i < 16; i++) begin
      h10[u][i] = 1'b0;
      h50[u][i] = 1'b0;
    end
    m_stb10[u] = 1'b0;
    m_stb50[u] = 1'b0;
    mq_n[u]    = 0;
    busy[u]    = 0;
    m_cr[u]    = 0;
    e_d10[u]   = 1'b0;
    e_d50[u]   = 1'b0;
    e_rej[u]   = 1'b0;
  endtask

  task automatic model_step(input int u);
    bit all10, all50, ev10, ev50, popped, ent;
    int free;
    all10 = 1'b1;
    all50 = 1'b1;
    for (int i = 1; i <= dval[u]; i++) begin
      if (h10[u][i] == m_stb10[u]) all10 = 1'b0;
      if (h50[u][i] == m_stb50[u]) all50 = 1'b0;
    end
    ev10 = all10 && !m_stb10[u];
    ev50 = all50 && !m_stb50[u];
    if (all10) m_stb10[u] = !m_stb10[u];
    if (all50) m_stb50[u] = !m_stb50[u];
    for (int i = 15; i > 0; i--) begin
      h10[u][i] = h10[u][i-1];
      h50[u][i] = h50[u][i-1];
    end
    h10[u][0] = coin_10_raw;
    h50[u][0] = coin_50_raw;

    free   = 4 - mq_n[u];
    popped = (busy[u] == 0) && (mq_n[u] > 0);
    ent    = 1'b0;
    if (popped) begin
      ent = mq[u][0];
      for (int i = 0; i < 3; i++) mq[u][i] = mq[u][i+1];
      mq_n[u]--;
      busy[u] = 2;
    end else if (busy[u] > 0) begin
      busy[u]--;
    end
    e_d10[u] = popped && !ent;
    e_d50[u] = popped && ent;

    e_rej[u] = 1'b0;
    if (ev10 || ev50) begin
      if (!accept_en) begin
        e_rej[u] = 1'b1;
      end else begin
        if (ev10) begin
          if (free > 0) begin
            mq[u][mq_n[u]] = 1'b0;
            mq_n[u]++;
            free--;
          end else begin
            e_rej[u] = 1'b1;
          end
        end
        if (ev50) begin
          if (free > 0) begin
            mq[u][mq_n[u]] = 1'b1;
            mq_n[u]++;
          end else begin
            e_rej[u] = 1'b1;
          end
        end
      end
    end

    if (credit_clr) m_cr[u] = 0;
    else if (popped) m_cr[u] = (m_cr[u] + (ent ? 5 : 1) > 255) ? 255 : m_cr[u] + (ent ? 5 : 1);
  endtask

  task automatic clear_stats();
    scen_t = 0;
    for (int u = 0; u < 2; u++) begin
      cnt10[u] = 0; cnt50[u] = 0; cntrej[u] = 0;
      first10[u] = -1; first50[u] = -1; maxlvl[u] = 0;
    end
  endtask

  task automatic check_unit(input int u, input logic d10, input logic d50, input logic rej,
                            input logic [2:0] lvl, input logic [7:0] cr);
    chk($sformatf("u%0d dollar_10", u), {7'd0, d10}, {7'd0, e_d10[u]});
    chk($sformatf("u%0d dollar_50", u), {7'd0, d50}, {7'd0, e_d50[u]});
    chk($sformatf("u%0d coin_reject", u), {7'd0, rej}, {7'd0, e_rej[u]});
    chk($sformatf("u%0d q_level", u), {5'd0, lvl}, 8'(mq_n[u]));
    chk($sformatf("u%0d credit", u), cr, 8'(m_cr[u]));
    chk($sformatf("u%0d dollar_exclusive", u), {7'd0, d10 & d50}, 8'd0);
    if (d10 === 1'b1) begin
      cnt10[u]++;
      if (first10[u] < 0) first10[u] = scen_t;
    end
    if (d50 === 1'b1) begin
      cnt50[u]++;
      if (first50[u] < 0) first50[u] = scen_t;
    end
    if (rej === 1'b1) cntrej[u]++;
    if (int'(lvl) > maxlvl[u]) maxlvl[u] = int'(lvl);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      model_step(0);
      model_step(1);
    end else begin
      model_reset(0);
      model_reset(1);
    end
    #1;
    check_unit(0, d10_a, d50_a, rej_a, lvl_a, cr_a);
    check_unit(1, d10_b, d50_b, rej_b, lvl_b, cr_b);
    scen_t++;
  endtask

  // Asserts reset away from the clock edge and checks its immediate effect.
  task automatic reset_pulse(input int cycles);
    reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_unit(0, d10_a, d50_a, rej_a, lvl_a, cr_a);
    check_unit(1, d10_b, d50_b, rej_b, lvl_b, cr_b);
    chk("u0 fsm_idle_in_reset", {6'd0, st_a}, 8'd0);
    chk("u1 fsm_idle_in_reset", {6'd0, st_b}, 8'd0);
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b1;
    coin_10_raw = 1'b0;
    coin_50_raw = 1'b0;
    accept_en   = 1'b1;
    credit_clr  = 1'b0;
    clear_stats();
    #2;
    reset_pulse(2);
    repeat (3) tick();

    // Single $10 coin held 10 cycles.
    clear_stats();
    coin_10_raw = 1'b1;
    repeat (10) tick();
    coin_10_raw = 1'b0;
    repeat (15) tick();
    chk("s1 u0 pulse_cycle", 8'(first10[0]), 8'd6);
    chk("s1 u0 pulse_count", 8'(cnt10[0]), 8'd1);
    chk("s1 u0 credit", cr_a, 8'd1);
    chk("s1 u0 q_level", {5'd0, lvl_a}, 8'd0);
    chk("s1 u1 pulse_cycle", 8'(first10[1]), 8'd4);
    chk("s1 u1 credit", cr_b, 8'd1);

    // Bouncing $50 sensor: toggles every cycle, never debounces.
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      coin_50_raw = ~coin_50_raw;
      tick();
    end
    coin_50_raw = 1'b0;
    repeat (10) tick();
    chk("s2 u0 pulses", 8'(cnt10[0] + cnt50[0] + cntrej[0]), 8'd0);
    chk("s2 u1 pulses", 8'(cnt10[1] + cnt50[1] + cntrej[1]), 8'd0);
    chk("s2 u0 credit", cr_a, 8'd1);

    // Both coins on the same edge into an empty queue.
    credit_clr = 1'b1;
    tick();
    credit_clr = 1'b0;
    clear_stats();
    coin_10_raw = 1'b1;
    coin_50_raw = 1'b1;
    repeat (8) tick();
    coin_10_raw = 1'b0;
    coin_50_raw = 1'b0;
    repeat (16) tick();
    chk("s3 u0 first10", 8'(first10[0]), 8'd6);
    chk("s3 u0 first50", 8'(first50[0]), 8'd9);
    chk("s3 u0 credit", cr_a, 8'd6);
    chk("s3 u1 first50", 8'(first50[1]), 8'd7);
    chk("s3 u1 credit", cr_b, 8'd6);

    // Coin pairs every 4 cycles on the short-debounce unit: queue fills.
    credit_clr = 1'b1;
    tick();
    credit_clr = 1'b0;
    clear_stats();
    for (int i = 0; i < 24; i++) begin
      coin_10_raw = (i % 4) < 2;
      coin_50_raw = (i % 4) < 2;
      tick();
    end
    coin_10_raw = 1'b0;
    coin_50_raw = 1'b0;
    repeat (30) tick();
    chk("s4 u1 max_level", 8'(maxlvl[1]), 8'd4);
    chk("s4 u1 dollar_10_count", 8'(cnt10[1]), 8'd6);
    chk("s4 u1 dollar_50_count", 8'(cnt50[1]), 8'd5);
    chk("s4 u1 reject_count", 8'(cntrej[1]), 8'd1);
    chk("s4 u1 credit", cr_b, 8'd31);
    chk("s4 u0 pulses", 8'(cnt10[0] + cnt50[0]), 8'd0);

    // Coins disabled: one $10 coin is rejected.
    accept_en  = 1'b0;
    credit_clr = 1'b1;
    tick();
    credit_clr = 1'b0;
    clear_stats();
    coin_10_raw = 1'b1;
    repeat (8) tick();
    coin_10_raw = 1'b0;
    repeat (12) tick();
    chk("s5 u0 reject_count", 8'(cntrej[0]), 8'd1);
    chk("s5 u0 dollar_count", 8'(cnt10[0] + cnt50[0]), 8'd0);
    chk("s5 u0 credit", cr_a, 8'd0);
    chk("s5 u1 reject_count", 8'(cntrej[1]), 8'd1);
    accept_en = 1'b1;
    repeat (4) tick();

    // Reset with three coins queued, raw $10 left high across release.
    for (int i = 0; i < 12; i++) begin
      coin_10_raw = (i % 4) < 2;
      coin_50_raw = (i % 4) < 2;
      tick();
    end
    chk("s6 u1 level_before_reset", {5'd0, lvl_b}, 8'd3);
    coin_10_raw = 1'b1;
    coin_50_raw = 1'b0;
    reset_pulse(3);
    clear_stats();
    repeat (12) tick();
    coin_10_raw = 1'b0;
    repeat (15) tick();
    chk("s6 u0 dollar_50_after_reset", 8'(cnt50[0]), 8'd0);
    chk("s6 u1 dollar_50_after_reset", 8'(cnt50[1]), 8'd0);
    chk("s6 u0 new_coin_cycle", 8'(first10[0]), 8'd6);
    chk("s6 u1 new_coin_count", 8'(cnt10[1]), 8'd1);

    // Long run of coin pairs: credit saturates.
    credit_clr = 1'b1;
    tick();
    credit_clr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      coin_10_raw = (i % 8) < 4;
      coin_50_raw = (i % 8) < 4;
      tick();
    end
    coin_10_raw = 1'b0;
    coin_50_raw = 1'b0;
    repeat (12) tick();
    chk("s7 u0 credit_saturated", cr_a, 8'd255);
    chk("s7 u1 credit_saturated", cr_b, 8'd255);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) coin_10_raw = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) coin_50_raw = 1'($urandom_range(1, 0));
      if ($urandom_range(19, 0) == 0) accept_en = ($urandom_range(3, 0) != 0);
      credit_clr = ($urandom_range(39, 0) == 0);
      if ($urandom_range(199, 0) == 0) reset_pulse(2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 2..255; consecutive stable cycles needed to accept a level change.
REQ-002 Parameter QDEPTH, fixed 4; number of entries in the coin queue.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 coin_10_raw  input  1  asynchronous, bouncy level from the $10 coin sensor; high while a coin passes.
REQ-006 coin_50_raw  input  1  asynchronous, bouncy level from the $50 coin sensor.
REQ-007 accept_en  input  1  1 = coins are accepted; 0 = every detected coin is rejected.
REQ-008 credit_clr  input  1  synchronous clear of credit.
REQ-009 dollar_10  output  1  one-cycle pulse per accepted $10 coin, for the vending machine.
REQ-010 dollar_50  output  1  one-cycle pulse per accepted $50 coin, for the vending machine.
REQ-011 coin_reject  output  1  one-cycle pulse per rejected coin.
REQ-012 q_level  output  3  current queue occupancy, 0..4.
REQ-013 credit  output  8  accepted value in $10 units, saturating at 255.

Function
REQ-014 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-015 Each channel SHALL hold a debounced level (stb) and a counter; the counter clears when sync2 == stb and increments when they differ.
REQ-016 stb SHALL take the value of sync2 on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on the same edge.
REQ-017 A coin event SHALL be the edge where stb goes 0->1; a 1->0 change produces no event.
REQ-018 Latency: with raw held high from first sampling edge k, the event occurs at edge k+DEBOUNCE_CYCLES+1.
REQ-019 An event with accept_en=0 SHALL be dropped and SHALL produce a coin_reject pulse in the following cycle.
REQ-020 An event with accept_en=1 SHALL push a 1-bit entry (0=$10, 1=$50) into a FIFO queue on the event edge.
REQ-021 Simultaneous $10 and $50 events SHALL push $10 first, then $50, in the same edge, provided at least 2 entries are free.
REQ-022 A push into a full queue SHALL be dropped with coin_reject. With exactly 1 free entry and simultaneous events: push $10, reject $50. One coin_reject pulse SHALL cover 1 or 2 rejects in the same edge.
REQ-023 Output FSM states: IDLE, PULSE, GAP.
REQ-024 IDLE: if the queue is non-empty at an edge, pop the head, drive dollar_10 or dollar_50 high for that entry, and go to PULSE.
REQ-025 PULSE: outputs return to 0 on the next edge and the FSM goes to GAP. GAP: go to IDLE on the next edge. Pulses are therefore separated by at least 2 low cycles.
REQ-026 dollar_10 and dollar_50 SHALL never be high in the same cycle.
REQ-027 Push and pop on the same edge SHALL both take effect; q_level reflects the net change.
REQ-028 credit SHALL increase by 1 or 5 on each pop ($10 or $50), saturating at 255. credit_clr has priority and clears credit to 0 on that edge. A pop on the clearing edge is not credited.
REQ-029 Changing accept_en SHALL not flush the queue; queued coins are still delivered.

Reset
REQ-030 reset_n=0 SHALL asynchronously force the following to 0: sync flops, stb, counters, queue pointers, q_level, credit, dollar_10, dollar_50, coin_reject. The FSM is forced to IDLE.
REQ-031 Reset mid-operation SHALL discard all queued coins and any pulse in flight, with no residual pulse after release.
REQ-032 After release, a raw input already high SHALL be treated as a new coin once debounced.

Verification
REQ-033 Scenario: DEBOUNCE_CYCLES=4, accept_en=1, coin_10_raw high for 10 cycles from edge k -> dollar_10 high only in cycle k+6; credit=1; q_level returns to 0.
REQ-034 Scenario: coin_50_raw toggles every cycle for 20 cycles, then stays 0 -> no pulse on any output; credit unchanged.
REQ-035 Scenario: both raw inputs rise on the same edge with an empty queue -> dollar_10 pulse, then 2 low cycles, then dollar_50 pulse; credit=6.
REQ-036 Scenario: 6 $50 coins detected while the FSM is busy -> exactly 4 dollar_50 pulses and 2 coin_reject pulses; credit=20.
REQ-037 Scenario: accept_en=0 and one $10 coin -> one coin_reject pulse, no dollar pulse, credit=0.
REQ-038 Scenario: reset_n asserted with 3 coins queued -> q_level=0 immediately; no dollar pulse after release.
